// File: rtl/laserdrop_pkg.sv
// Shared LaserDrop definitions: FTDI adapter state encoding, default pulse
// timing and the framing constants used by the protocol FSM.
package laserdrop_pkg;

   typedef enum logic [2:0] {
      FTDI_IDLE       = 3'd0,
      FTDI_RD_ASSERT  = 3'd1,
      FTDI_RD_RECOVER = 3'd2,
      FTDI_WR_SETUP   = 3'd3,
      FTDI_WR_ASSERT  = 3'd4,
      FTDI_WR_RECOVER = 3'd5
   } ftdi_state_t;

   // Default FT232H 245-FIFO pulse timing in CLOCK_50 cycles.
   localparam int FTDI_RD_LOW_DEF   = 4;
   localparam int FTDI_RD_HIGH_DEF  = 2;
   localparam int FTDI_WR_SETUP_DEF = 1;
   localparam int FTDI_WR_LOW_DEF   = 4;
   localparam int FTDI_WR_HIGH_DEF  = 2;

   localparam int FTDI_CNT_W = 8;

   localparam logic [7:0] START_SEQ = 8'hAA;
   localparam logic [7:0] STOP_SEQ  = 8'h55;
   localparam logic [7:0] ACK_SEQ   = 8'hCC;
   localparam logic [7:0] DONE_SEQ  = 8'h33;

   localparam int PKT_HDR_BYTES     = 2;
   localparam int PKT_PAYLOAD_BYTES = 16;
   localparam int PKT_LEN_BYTES     = PKT_HDR_BYTES + PKT_PAYLOAD_BYTES;

   // The state timer counts down to zero, so an N-cycle state loads N-1.
   function automatic logic [FTDI_CNT_W-1:0] ftdi_cnt_load(input int cycles);
      return FTDI_CNT_W'(cycles - 1);
   endfunction

endpackage

// File: rtl/ftdi_fifo_if_if.sv
// Bundle of FT232H FIFO pins and the byte-level rx/tx streams; the master
// modport is the adapter, the slave modport is everything around it.
interface ftdi_fifo_if_if;

   logic       rxf_n;
   logic       txe_n;
   logic [7:0] adbus_in;
   logic [7:0] adbus_out;
   logic       adbus_oe;
   logic       rd_n;
   logic       wr_n;

   logic [7:0] rx_data;
   logic       rx_valid;
   logic       rx_ready;

   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_ready;

   modport master (
      input  rxf_n, txe_n, adbus_in, rx_ready, tx_data, tx_valid,
      output adbus_out, adbus_oe, rd_n, wr_n, rx_data, rx_valid, tx_ready
   );

   modport slave (
      output rxf_n, txe_n, adbus_in, rx_ready, tx_data, tx_valid,
      input  adbus_out, adbus_oe, rd_n, wr_n, rx_data, rx_valid, tx_ready
   );

endinterface

// File: rtl/ftdi_sync2.sv
// Two-flop synchroniser with configurable reset value; BYPASS passes the
// raw input straight through for simulation-only builds.
module ftdi_sync2 #(
   parameter logic RESET_VAL = 1'b1,
   parameter bit   BYPASS    = 1'b0
) (
   input  logic clock,
   input  logic resetN,
   input  logic d,
   output logic q
);

   logic meta_d, meta_q;
   logic sync_d, sync_q;

   always_comb begin
      meta_d = d;
      sync_d = meta_q;
   end

   always_ff @(posedge clock) begin
      if (!resetN) begin
         meta_q <= RESET_VAL;
         sync_q <= RESET_VAL;
      end else begin
         meta_q <= meta_d;
         sync_q <= sync_d;
      end
   end

   assign q = BYPASS ? d : sync_q;

endmodule

// File: rtl/ftdi_fifo_if.sv
// FT232H async 245-FIFO to byte-stream adapter: owns RD#/WR# pulse timing,
// bus turnaround and read/write arbitration. Define FTDI_SYNC_EN to
// synchronise RXF#/TXE# (required on hardware).
module ftdi_fifo_if
   import laserdrop_pkg::*;
#(
   parameter int RD_LOW   = FTDI_RD_LOW_DEF,
   parameter int RD_HIGH  = FTDI_RD_HIGH_DEF,
   parameter int WR_SETUP = FTDI_WR_SETUP_DEF,
   parameter int WR_LOW   = FTDI_WR_LOW_DEF,
   parameter int WR_HIGH  = FTDI_WR_HIGH_DEF
) (
   input logic            clock,
   input logic            resetN,
   ftdi_fifo_if_if.master bus
);

   localparam logic [2:0] ST_IDLE       = FTDI_IDLE;
   localparam logic [2:0] ST_RD_ASSERT  = FTDI_RD_ASSERT;
   localparam logic [2:0] ST_RD_RECOVER = FTDI_RD_RECOVER;
   localparam logic [2:0] ST_WR_SETUP   = FTDI_WR_SETUP;
   localparam logic [2:0] ST_WR_ASSERT  = FTDI_WR_ASSERT;
   localparam logic [2:0] ST_WR_RECOVER = FTDI_WR_RECOVER;

   localparam logic [FTDI_CNT_W-1:0] RD_LOW_LD   = ftdi_cnt_load(RD_LOW);
   localparam logic [FTDI_CNT_W-1:0] RD_HIGH_LD  = ftdi_cnt_load(RD_HIGH);
   localparam logic [FTDI_CNT_W-1:0] WR_SETUP_LD = ftdi_cnt_load(WR_SETUP);
   localparam logic [FTDI_CNT_W-1:0] WR_LOW_LD   = ftdi_cnt_load(WR_LOW);
   localparam logic [FTDI_CNT_W-1:0] WR_HIGH_LD  = ftdi_cnt_load(WR_HIGH);

`ifdef FTDI_SYNC_EN
   localparam bit SYNC_BYPASS = 1'b0;
`else
   localparam bit SYNC_BYPASS = 1'b1;
`endif

   logic rxf_s;
   logic txe_s;

   ftdi_sync2 #(.RESET_VAL(1'b1), .BYPASS(SYNC_BYPASS)) u_rxf_sync (
      .clock  (clock),
      .resetN (resetN),
      .d      (bus.rxf_n),
      .q      (rxf_s)
   );

   ftdi_sync2 #(.RESET_VAL(1'b1), .BYPASS(SYNC_BYPASS)) u_txe_sync (
      .clock  (clock),
      .resetN (resetN),
      .d      (bus.txe_n),
      .q      (txe_s)
   );

   logic [2:0]            state_d, state_q;
   logic [FTDI_CNT_W-1:0] cnt_d, cnt_q;
   logic                  rd_n_d, rd_n_q;
   logic                  wr_n_d, wr_n_q;
   logic                  adbus_oe_d, adbus_oe_q;
   logic [7:0]            adbus_out_d, adbus_out_q;
   logic [7:0]            rx_data_d, rx_data_q;
   logic                  rx_valid_d, rx_valid_q;
   logic                  tx_ready_d, tx_ready_q;
   logic                  last_rd_d, last_rd_q;

   logic rd_ok;
   logic wr_ok;
   logic take_rd;
   logic cnt_done;

   // The RX holding register has one entry, so a held byte blocks reads.
   always_comb begin
      rd_ok    = !rxf_s && !rx_valid_q;
      wr_ok    = !txe_s && bus.tx_valid;
      take_rd  = rd_ok && (!wr_ok || !last_rd_q);
      cnt_done = (cnt_q == '0);
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      rd_n_d      = rd_n_q;
      wr_n_d      = wr_n_q;
      adbus_oe_d  = adbus_oe_q;
      adbus_out_d = adbus_out_q;
      rx_data_d   = rx_data_q;
      rx_valid_d  = rx_valid_q;
      tx_ready_d  = 1'b0;
      last_rd_d   = last_rd_q;

      if (rx_valid_q && bus.rx_ready) begin
         rx_valid_d = 1'b0;
      end

      case (state_q)
         ST_IDLE: begin
            if (take_rd) begin
               state_d = ST_RD_ASSERT;
               cnt_d   = RD_LOW_LD;
               rd_n_d  = 1'b0;
            end else if (wr_ok) begin
               state_d     = ST_WR_SETUP;
               cnt_d       = WR_SETUP_LD;
               adbus_out_d = bus.tx_data;
               adbus_oe_d  = 1'b1;
               tx_ready_d  = 1'b1;
            end
         end

         ST_RD_ASSERT: begin
            if (cnt_done) begin
               state_d    = ST_RD_RECOVER;
               cnt_d      = RD_HIGH_LD;
               rd_n_d     = 1'b1;
               rx_data_d  = bus.adbus_in;
               rx_valid_d = 1'b1;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end

         ST_RD_RECOVER: begin
            if (cnt_done) begin
               state_d   = ST_IDLE;
               last_rd_d = 1'b1;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end

         ST_WR_SETUP: begin
            if (cnt_done) begin
               state_d = ST_WR_ASSERT;
               cnt_d   = WR_LOW_LD;
               wr_n_d  = 1'b0;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end

         ST_WR_ASSERT: begin
            if (cnt_done) begin
               state_d = ST_WR_RECOVER;
               cnt_d   = WR_HIGH_LD;
               wr_n_d  = 1'b1;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end

         // Bus stays driven for the first recovery cycle only (hold time).
         ST_WR_RECOVER: begin
            adbus_oe_d = 1'b0;
            if (cnt_done) begin
               state_d   = ST_IDLE;
               last_rd_d = 1'b0;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end

         default: begin
            state_d    = ST_IDLE;
            cnt_d      = '0;
            rd_n_d     = 1'b1;
            wr_n_d     = 1'b1;
            adbus_oe_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clock) begin
      if (!resetN) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         rd_n_q      <= 1'b1;
         wr_n_q      <= 1'b1;
         adbus_oe_q  <= 1'b0;
         adbus_out_q <= '0;
         rx_data_q   <= '0;
         rx_valid_q  <= 1'b0;
         tx_ready_q  <= 1'b0;
         last_rd_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         rd_n_q      <= rd_n_d;
         wr_n_q      <= wr_n_d;
         adbus_oe_q  <= adbus_oe_d;
         adbus_out_q <= adbus_out_d;
         rx_data_q   <= rx_data_d;
         rx_valid_q  <= rx_valid_d;
         tx_ready_q  <= tx_ready_d;
         last_rd_q   <= last_rd_d;
      end
   end

   assign bus.rd_n      = rd_n_q;
   assign bus.wr_n      = wr_n_q;
   assign bus.adbus_oe  = adbus_oe_q;
   assign bus.adbus_out = adbus_out_q;
   assign bus.rx_data   = rx_data_q;
   assign bus.rx_valid  = rx_valid_q;
   assign bus.tx_ready  = tx_ready_q;

endmodule

// File: tb/tb_ftdi_fifo_if.sv
// Scoreboard bench for ftdi_fifo_if: a behavioural FT232H/host model drives
// the pins, expected bytes are queued at issue time and a monitor checks them.
module tb_ftdi_fifo_if;

   localparam int RD_LOW   = 4;
   localparam int RD_HIGH  = 2;
   localparam int WR_SETUP = 1;
   localparam int WR_LOW   = 4;
`ifdef FTDI_SYNC_EN
   localparam int EXP_LAT = 3;
`else
   localparam int EXP_LAT = 1;
`endif

   logic clock = 1'b0;
   logic resetN;

   ftdi_fifo_if_if bus ();

   ftdi_fifo_if dut (
      .clock  (clock),
      .resetN (resetN),
      .bus    (bus)
   );

   always #5 clock = ~clock;

   int n_checks = 0;
   int n_fail   = 0;

   logic [7:0] host_q[$];
   logic [7:0] prod_q[$];
   logic [7:0] rx_exp_q[$];
   logic [7:0] tx_exp_q[$];
   bit         op_log[$];

   bit mon_en  = 1'b0;
   int rx_mode = 1;
   int txe_mode = 0;

   int rd_count    = 0;
   int last_rx_run = 0;

   task automatic checkOutput(input bit ok, input string name, input int act, input int exp);
      n_checks++;
      if (!ok) begin
         n_fail++;
         $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic applyStimulus(input bit is_tx, input logic [7:0] b);
      if (is_tx) begin
         prod_q.push_back(b);
         tx_exp_q.push_back(b);
      end else begin
         host_q.push_back(b);
         rx_exp_q.push_back(b);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #2;
   endtask

   // FT232H, host and byte-stream producer/consumer model; inputs change 1 time unit after each edge.
   initial begin
      logic drv_prev_rd_n;
      drv_prev_rd_n = 1'b1;
      bus.rxf_n    = 1'b1;
      bus.txe_n    = 1'b1;
      bus.adbus_in = 8'h00;
      bus.tx_valid = 1'b0;
      bus.tx_data  = 8'h00;
      bus.rx_ready = 1'b0;
      forever begin
         @(posedge clock);
         #1;
         if (!drv_prev_rd_n && bus.rd_n && host_q.size() > 0) host_q.pop_front();
         drv_prev_rd_n = bus.rd_n;
         bus.rxf_n    = (host_q.size() == 0);
         bus.adbus_in = (host_q.size() > 0) ? host_q[0] : 8'($urandom());
         if (bus.tx_ready && prod_q.size() > 0) prod_q.pop_front();
         bus.tx_valid = (prod_q.size() > 0);
         bus.tx_data  = (prod_q.size() > 0) ? prod_q[0] : 8'($urandom());
         case (rx_mode)
            0:       bus.rx_ready = 1'b0;
            1:       bus.rx_ready = 1'b1;
            default: bus.rx_ready = 1'($urandom_range(0, 1));
         endcase
         bus.txe_n = (txe_mode == 0) ? 1'b0 : ($urandom_range(0, 3) == 0);
      end
   end

   // Monitor: pulse widths, turnaround, data against the expectation queues.
   logic       prev_rd_n, prev_wr_n, prev_tx_ready;
   int         rd_low_cnt, rd_high_cnt, wr_low_cnt, setup_cnt, post_cnt, rx_run;
   bit         rd_seen, post_active;
   logic [7:0] cur_wr_exp;

   always @(negedge clock) begin
      if (!mon_en) begin
         prev_rd_n     = bus.rd_n;
         prev_wr_n     = bus.wr_n;
         prev_tx_ready = bus.tx_ready;
         rd_seen       = 1'b0;
         post_active   = 1'b0;
         setup_cnt     = 0;
         rx_run        = 0;
      end else begin
         if (!bus.rd_n) checkOutput(!bus.adbus_oe, "oe_while_rd_low", int'(bus.adbus_oe), 0);
         if (prev_rd_n && !bus.rd_n) begin
            if (rd_seen) checkOutput(rd_high_cnt >= RD_HIGH, "rd_high_gap", rd_high_cnt, RD_HIGH);
            checkOutput(!bus.rx_valid, "rd_while_byte_held", int'(bus.rx_valid), 0);
            rd_low_cnt = 1;
            rd_count++;
            op_log.push_back(1'b0);
         end else if (!bus.rd_n) begin
            rd_low_cnt++;
         end else if (!prev_rd_n && bus.rd_n) begin
            checkOutput(rd_low_cnt == RD_LOW, "rd_low_width", rd_low_cnt, RD_LOW);
            checkOutput(bus.rx_valid, "rx_valid_on_rd_rise", int'(bus.rx_valid), 1);
            rd_high_cnt = 1;
            rd_seen     = 1'b1;
         end else if (rd_high_cnt < 100000) begin
            rd_high_cnt++;
         end

         if (prev_wr_n && !bus.wr_n) begin
            checkOutput(setup_cnt == WR_SETUP, "wr_setup_cycles", setup_cnt, WR_SETUP);
            checkOutput(bus.adbus_oe, "oe_at_wr_fall", int'(bus.adbus_oe), 1);
            if (tx_exp_q.size() == 0) begin
               checkOutput(1'b0, "wr_unexpected", int'(bus.adbus_out), -1);
               cur_wr_exp = 8'h00;
            end else begin
               cur_wr_exp = tx_exp_q.pop_front();
               checkOutput(bus.adbus_out == cur_wr_exp, "wr_data_at_fall", int'(bus.adbus_out), int'(cur_wr_exp));
            end
            wr_low_cnt = 1;
            setup_cnt  = 0;
            op_log.push_back(1'b1);
         end else if (!bus.wr_n) begin
            wr_low_cnt++;
         end else if (!prev_wr_n && bus.wr_n) begin
            checkOutput(wr_low_cnt == WR_LOW, "wr_low_width", wr_low_cnt, WR_LOW);
            checkOutput(bus.adbus_oe, "oe_hold_after_wr", int'(bus.adbus_oe), 1);
            checkOutput(bus.adbus_out == cur_wr_exp, "wr_data_at_rise", int'(bus.adbus_out), int'(cur_wr_exp));
            post_active = 1'b1;
            post_cnt    = 1;
         end else if (post_active) begin
            if (!bus.adbus_oe) begin
               checkOutput(post_cnt == 1, "oe_drop_delay", post_cnt, 1);
               post_active = 1'b0;
            end else begin
               post_cnt++;
            end
         end else if (bus.adbus_oe) begin
            setup_cnt++;
         end

         if (bus.rx_valid) begin
            rx_run++;
            if (rx_exp_q.size() == 0) begin
               checkOutput(1'b0, "rx_unexpected", int'(bus.rx_data), -1);
            end else begin
               checkOutput(bus.rx_data == rx_exp_q[0], "rx_data", int'(bus.rx_data), int'(rx_exp_q[0]));
               if (bus.rx_ready) void'(rx_exp_q.pop_front());
            end
         end else if (rx_run > 0) begin
            last_rx_run = rx_run;
            rx_run      = 0;
         end

         if (bus.tx_ready) begin
            checkOutput(!prev_tx_ready, "tx_ready_single_pulse", int'(prev_tx_ready), 0);
            checkOutput(bus.adbus_oe, "oe_with_tx_ready", int'(bus.adbus_oe), 1);
         end

         prev_rd_n     = bus.rd_n;
         prev_wr_n     = bus.wr_n;
         prev_tx_ready = bus.tx_ready;
      end
   end

   task automatic waitDrain(input int max_cycles);
      int n;
      n = 0;
      while ((host_q.size() > 0 || prod_q.size() > 0 || !bus.rd_n || !bus.wr_n ||
              bus.adbus_oe || bus.rx_valid) && n < max_cycles) begin
         @(negedge clock);
         n++;
      end
      tick();
      checkOutput(n < max_cycles, "drain_timeout", n, max_cycles);
      checkOutput(rx_exp_q.size() == 0, "rx_bytes_missing", rx_exp_q.size(), 0);
      checkOutput(tx_exp_q.size() == 0, "tx_bytes_missing", tx_exp_q.size(), 0);
   endtask

   task automatic doReset();
      mon_en = 1'b0;
      resetN = 1'b0;
      repeat (3) tick();
      host_q.delete();
      prod_q.delete();
      rx_exp_q.delete();
      tx_exp_q.delete();
      resetN = 1'b1;
      repeat (4) tick();
   endtask

   initial begin
      int n;
      int start_rd;
      resetN = 1'b0;
      doReset();
      checkOutput(bus.rd_n && bus.wr_n, "reset_rd_wr_high", int'({bus.rd_n, bus.wr_n}), 3);
      checkOutput(!bus.adbus_oe && bus.adbus_out == 8'h00, "reset_bus", int'(bus.adbus_out), 0);
      checkOutput(!bus.rx_valid && bus.rx_data == 8'h00, "reset_rx", int'(bus.rx_data), 0);
      checkOutput(!bus.tx_ready, "reset_tx_ready", int'(bus.tx_ready), 0);
      mon_en = 1'b1;

      $display("[TB] single read of 0xA5");
      applyStimulus(1'b0, 8'hA5);
      waitDrain(200);
      checkOutput(last_rx_run == 1, "rx_valid_width", last_rx_run, 1);

      $display("[TB] single write of 0x3C");
      applyStimulus(1'b1, 8'h3C);
      waitDrain(200);

      $display("[TB] round-robin arbitration");
      doReset();
      mon_en = 1'b1;
      op_log.delete();
      applyStimulus(1'b0, 8'h11);
      applyStimulus(1'b0, 8'h22);
      repeat (4) tick();
      applyStimulus(1'b1, 8'h81);
      applyStimulus(1'b1, 8'h82);
      waitDrain(400);
      checkOutput(op_log.size() == 4, "arb_op_count", op_log.size(), 4);
      for (int i = 0; i < op_log.size() && i < 4; i++) begin
         checkOutput(op_log[i] == bit'(i % 2), "arb_order", int'(op_log[i]), i % 2);
      end

      $display("[TB] rx backpressure");
      rx_mode  = 0;
      start_rd = rd_count;
      for (int i = 0; i < 3; i++) applyStimulus(1'b0, 8'($urandom()));
      repeat (40) tick();
      checkOutput(rd_count - start_rd == 1, "reads_while_held", rd_count - start_rd, 1);
      rx_mode = 1;
      waitDrain(400);
      checkOutput(rd_count - start_rd == 3, "reads_after_release", rd_count - start_rd, 3);

      $display("[TB] reset during read pulse");
      mon_en = 1'b0;
      host_q.push_back(8'h5A);
      n = 0;
      do begin
         tick();
         n++;
      end while (bus.rd_n && n < 20);
      checkOutput(n < 20, "rd_start_timeout", n, 20);
      tick();
      resetN = 1'b0;
      @(posedge clock);
      @(negedge clock);
      checkOutput(bus.rd_n, "abort_rd_n", int'(bus.rd_n), 1);
      checkOutput(!bus.rx_valid, "abort_rx_valid", int'(bus.rx_valid), 0);
      checkOutput(!bus.adbus_oe, "abort_oe", int'(bus.adbus_oe), 0);
      tick();
      host_q.delete();
      rx_exp_q.delete();
      resetN = 1'b1;
      repeat (5) tick();
      mon_en = 1'b1;
      applyStimulus(1'b0, 8'hC3);
      tick();
      checkOutput(!bus.rxf_n, "rxf_asserted", int'(bus.rxf_n), 0);
      n = 0;
      do begin
         tick();
         n++;
      end while (bus.rd_n && n < 20);
      checkOutput(n == EXP_LAT, "rxf_to_rd_latency", n, EXP_LAT);
      waitDrain(200);

      $display("[TB] randomized traffic");
      rx_mode  = 2;
      txe_mode = 1;
      for (int c = 0; c < 1500; c++) begin
         tick();
         if (host_q.size() < 4 && $urandom_range(0, 3) == 0) applyStimulus(1'b0, 8'($urandom()));
         if (prod_q.size() < 4 && $urandom_range(0, 3) == 0) applyStimulus(1'b1, 8'($urandom()));
      end
      txe_mode = 0;
      rx_mode  = 1;
      waitDrain(3000);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
